// File: rtl/mc_control_fsm_pkg.sv
// Shared CPU package: opcodes, FSM states, datapath select codes.
// Also carries the funct codes consumed by the ALU control unit.
package mc_control_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH  = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
    } ctrl_t;

    function automatic logic op_legal(logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW,
            OP_BEQ, OP_J, OP_ADDI: return 1'b1;
            default:               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Controller <-> datapath bundle: opcode and memory handshake in,
// strobes, selects and debug/status out.
interface mc_control_fsm_if #(
    parameter int CNT_W = 16
) ();
    logic [5:0]       i_opcode;
    logic             i_mem_ready;
    logic             o_PCWrite;
    logic             o_PCWriteCond;
    logic             o_IorD;
    logic             o_MemRead;
    logic             o_MemWrite;
    logic             o_MemtoReg;
    logic             o_IRWrite;
    logic             o_ALUSrcA;
    logic             o_RegWrite;
    logic             o_RegDst;
    logic [1:0]       o_ALUOp;
    logic [1:0]       o_ALUSrcB;
    logic [1:0]       o_PCSource;
    logic [3:0]       o_state;
    logic             o_illegal;
    logic [CNT_W-1:0] o_retired;

    modport master (
        output i_opcode, i_mem_ready,
        input  o_PCWrite, o_PCWriteCond, o_IorD, o_MemRead,
        input  o_MemWrite, o_MemtoReg, o_IRWrite, o_ALUSrcA,
        input  o_RegWrite, o_RegDst, o_ALUOp, o_ALUSrcB,
        input  o_PCSource, o_state, o_illegal, o_retired
    );

    modport slave (
        input  i_opcode, i_mem_ready,
        output o_PCWrite, o_PCWriteCond, o_IorD, o_MemRead,
        output o_MemWrite, o_MemtoReg, o_IRWrite, o_ALUSrcA,
        output o_RegWrite, o_RegDst, o_ALUOp, o_ALUSrcB,
        output o_PCSource, o_state, o_illegal, o_retired
    );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Moore output decode for the multicycle controller; only the FETCH
// IR/PC write strobes look at the memory handshake.
module mc_ctrl_decode
    import mc_control_fsm_pkg::*;
(
    input  state_e state_i,
    input  logic   mem_ready_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMMSH;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
            end
            S_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REG;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_REG;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
            end
            S_ADDIWB: begin
                ctrl_o.reg_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-style main controller: state register, next-state
// logic and retired-instruction counter.
module mc_control_fsm
    import mc_control_fsm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic            i_clk,
    input  logic            i_reset,
    mc_control_fsm_if.slave bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;
    logic             rdy;
    logic [5:0]       op;
    ctrl_t            ctrl;

    assign rdy = bus.i_mem_ready;
    assign op  = bus.i_opcode;

    always_comb begin
        state_d = S_FETCH;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:  state_d = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = rdy ? S_MEMWB : S_MEMRD;
            S_MEMWR: begin
                state_d = rdy ? S_FETCH : S_MEMWR;
                retire  = rdy;
            end
            S_EXEC:   state_d = S_RWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_RWB, S_BRANCH,
            S_JUMP, S_ADDIWB: retire = 1'b1;
            default:  state_d = S_FETCH;
        endcase
        retired_d = retire ? retired_q + 1'b1 : retired_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    mc_ctrl_decode u_decode (
        .state_i     (state_q),
        .mem_ready_i (rdy),
        .ctrl_o      (ctrl)
    );

    // Side-effecting strobes are held off for the whole reset cycle.
    assign bus.o_PCWrite     = ctrl.pc_write      & ~i_reset;
    assign bus.o_PCWriteCond = ctrl.pc_write_cond & ~i_reset;
    assign bus.o_MemRead     = ctrl.mem_read      & ~i_reset;
    assign bus.o_MemWrite    = ctrl.mem_write     & ~i_reset;
    assign bus.o_IRWrite     = ctrl.ir_write      & ~i_reset;
    assign bus.o_RegWrite    = ctrl.reg_write     & ~i_reset;
    assign bus.o_IorD        = ctrl.iord;
    assign bus.o_MemtoReg    = ctrl.mem_to_reg;
    assign bus.o_ALUSrcA     = ctrl.alu_src_a;
    assign bus.o_RegDst      = ctrl.reg_dst;
    assign bus.o_ALUOp       = ctrl.alu_op;
    assign bus.o_ALUSrcB     = ctrl.alu_src_b;
    assign bus.o_PCSource    = ctrl.pc_source;
    assign bus.o_state       = state_q;
    assign bus.o_retired     = retired_q;
    assign bus.o_illegal     = (state_q == S_DECODE) & ~op_legal(op)
                             & ~i_reset;

endmodule
